// File: rtl/rr_mux_pkg.sv
// Shared definitions for the round-robin mux select generator:
// source count, select width, FSM encoding and the rotate-priority search.
package rr_mux_pkg;

    localparam int N_SRC = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } rr_state_e;

    // Returns {found, idx}: first set request bit searching ptr, ptr+1, ...
    // with natural 2-bit wrap. idx equals ptr when nothing is found.
    function automatic logic [SEL_W:0] rr_pick(input logic [N_SRC-1:0] req,
                                               input logic [SEL_W-1:0] ptr);
        logic             found;
        logic [SEL_W-1:0] idx;
        logic [SEL_W-1:0] cand;
        found = 1'b0;
        idx   = ptr;
        cand  = ptr;
        for (int k = 0; k < N_SRC; k++) begin
            cand = ptr + SEL_W'(k);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end else begin
                found = found;
            end
        end
        return {found, idx};
    endfunction

endpackage

// File: rtl/rr_mux_sel_if.sv
// Request/grant bundle between requesters, the select generator and the mux.
// master: requester side (drives req/done). slave: rr_mux_sel.
interface rr_mux_sel_if;
    import rr_mux_pkg::*;

    logic [N_SRC-1:0] req;
    logic             done;
    logic [SEL_W-1:0] s;
    logic [N_SRC-1:0] gnt;
    logic             gnt_valid;
    logic             preempt;

    modport master (
        output req, done,
        input  s, gnt, gnt_valid, preempt
    );

    modport slave (
        input  req, done,
        output s, gnt, gnt_valid, preempt
    );

endinterface

// File: rtl/rr_prio_pick.sv
// Combinational rotate-priority encoder: highest priority at ptr, then
// ptr+1 .. ptr+3 (mod 4). found=0 when no request bit is set.
module rr_prio_pick
    import rr_mux_pkg::*;
(
    input  logic [N_SRC-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    // Rotating first-set search over the request vector
    always_comb begin
        {found, idx} = rr_pick(req, ptr);
    end

endmodule

// File: rtl/rr_mux_sel.sv
// Round-robin select generator feeding a 4:1 mux select. The select is held
// while a source owns the channel and rotates on release (done pulse, owner
// dropping its request, or optional hold timeout). All outputs are registered.
// Optional feature: define RR_SEL_TIMEOUT_EN to enable the hold-limit
// timeout and the preempt pulse; without it preempt is constant 0.
module rr_mux_sel
    import rr_mux_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic         clk,
    input  logic         rst,
    rr_mux_sel_if.slave  bus
);

    // Reject hold limits the counter cannot represent
    if (MAX_HOLD < 2 || MAX_HOLD > (1 << CNT_W) - 1) begin : g_bad_max_hold
        $error("rr_mux_sel: MAX_HOLD outside 2..2^CNT_W-1");
    end

    rr_state_e        state_q, state_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [SEL_W-1:0] s_q, s_d;
    logic [N_SRC-1:0] gnt_q, gnt_d;
    logic             gnt_valid_q, gnt_valid_d;
    logic             preempt_q, preempt_d;

    logic [N_SRC-1:0] owner_mask_s;
    logic             owner_req_s;
    logic             others_req_s;
    logic             timeout_s;
    logic             release_s;
    logic [N_SRC-1:0] pick_req_s;
    logic [SEL_W-1:0] pick_ptr_s;
    logic             pick_found_s;
    logic [SEL_W-1:0] pick_idx_s;
    logic [N_SRC-1:0] pick_onehot_s;

`ifdef RR_SEL_TIMEOUT_EN
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
`endif

    // Release detection and arbitration inputs for the single priority encoder
    always_comb begin
        owner_mask_s = {{(N_SRC-1){1'b0}}, 1'b1} << s_q;
        owner_req_s  = |(bus.req & owner_mask_s);
        others_req_s = |(bus.req & ~owner_mask_s);
`ifdef RR_SEL_TIMEOUT_EN
        // >= also covers a counter that saturated while the owner was alone
        timeout_s    = (hold_cnt_q >= CNT_W'(MAX_HOLD - 1)) && others_req_s;
`else
        timeout_s    = 1'b0;
`endif
        if (state_q == BUSY) begin
            release_s  = bus.done || !owner_req_s || timeout_s;
            // Outgoing owner is always masked: lowest priority and not re-picked
            pick_req_s = bus.req & ~owner_mask_s;
            pick_ptr_s = s_q + 2'd1;
        end else begin
            release_s  = 1'b0;
            pick_req_s = bus.req;
            pick_ptr_s = ptr_q;
        end
    end

    rr_prio_pick u_pick (
        .req   (pick_req_s),
        .ptr   (pick_ptr_s),
        .found (pick_found_s),
        .idx   (pick_idx_s)
    );

    assign pick_onehot_s = {{(N_SRC-1){1'b0}}, 1'b1} << pick_idx_s;

    // State register: FSM state, pointer and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= 2'b00;
            s_q         <= 2'b00;
            gnt_q       <= 4'b0000;
            gnt_valid_q <= 1'b0;
            preempt_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            s_q         <= s_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            preempt_q   <= preempt_d;
        end
    end

`ifdef RR_SEL_TIMEOUT_EN
    // Hold counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt_q <= {CNT_W{1'b0}};
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end
`endif

    // Next-state logic: grant from IDLE, rotate or fall back to IDLE on release
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (pick_found_s) begin
                    state_d = BUSY;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (release_s) begin
                    ptr_d = s_q + 2'd1;
                    if (pick_found_s) begin
                        state_d = BUSY;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = BUSY;
                end
            end
            default: begin
                state_d = IDLE;
                ptr_d   = 2'b00;
            end
        endcase
    end

    // Output logic: next values of select, grant, valid, preempt and counter
    always_comb begin
        s_d         = s_q;
        gnt_d       = gnt_q;
        gnt_valid_d = gnt_valid_q;
        preempt_d   = 1'b0;
`ifdef RR_SEL_TIMEOUT_EN
        hold_cnt_d  = hold_cnt_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef RR_SEL_TIMEOUT_EN
                hold_cnt_d = {CNT_W{1'b0}};
`endif
                if (pick_found_s) begin
                    s_d         = pick_idx_s;
                    gnt_d       = pick_onehot_s;
                    gnt_valid_d = 1'b1;
                end else begin
                    gnt_d       = 4'b0000;
                    gnt_valid_d = 1'b0;
                end
            end
            BUSY: begin
                if (release_s && pick_found_s) begin
                    s_d         = pick_idx_s;
                    gnt_d       = pick_onehot_s;
                    gnt_valid_d = 1'b1;
                    // Flag only releases forced by the timeout alone
                    preempt_d   = timeout_s && !bus.done && owner_req_s;
`ifdef RR_SEL_TIMEOUT_EN
                    hold_cnt_d  = {CNT_W{1'b0}};
`endif
                end else if (release_s) begin
                    gnt_d       = 4'b0000;
                    gnt_valid_d = 1'b0;
`ifdef RR_SEL_TIMEOUT_EN
                    hold_cnt_d  = {CNT_W{1'b0}};
`endif
                end else begin
`ifdef RR_SEL_TIMEOUT_EN
                    if (hold_cnt_q < CNT_W'(MAX_HOLD)) begin
                        hold_cnt_d = hold_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        hold_cnt_d = hold_cnt_q;
                    end
`else
                    preempt_d = 1'b0;
`endif
                end
            end
            default: begin
                gnt_d       = 4'b0000;
                gnt_valid_d = 1'b0;
            end
        endcase
    end

    assign bus.s         = s_q;
    assign bus.gnt       = gnt_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.preempt   = preempt_q;

endmodule
